// File: rtl/mul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_ctrl : sequencer for the repeated-addition multiplier datapath.      |
// | Optional build macro: MUL_ZERO_SKIP_EN (bypass loop on a zero operand).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mul_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             eqz,
  output logic [WIDTH-1:0] data_out,
  output logic             lda,
  output logic             ldb,
  output logic             clrp,
  output logic             ldp,
  output logic             decb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             w_accept;
  logic             w_skip;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef MUL_ZERO_SKIP_EN
  // A zero operand makes the product zero: load B=0 so ADD exits at once.
  assign w_skip = (a_in == '0) || (b_in == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= a_in;
      r_b <= w_skip ? '0 : b_in;
    end
  end

  always_comb begin
    w_next   = r_state;
    data_out = '0;
    lda      = 1'b0;
    ldb      = 1'b0;
    clrp     = 1'b0;
    ldp      = 1'b0;
    decb     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_skip ? S_LDB : S_LDA;
        end
      end
      S_LDA: begin
        data_out = r_a;
        lda      = 1'b1;
        busy     = 1'b1;
        w_next   = S_LDB;
      end
      S_LDB: begin
        data_out = r_b;
        ldb      = 1'b1;
        clrp     = 1'b1;
        busy     = 1'b1;
        w_next   = S_ADD;
      end
      S_ADD: begin
        // Accumulate strobes follow the live counter flag, not a registered copy.
        busy = 1'b1;
        ldp  = ~eqz;
        decb = ~eqz;
        if (eqz) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// Bench for mul_ctrl: behavioural datapath, vector table, scoreboard of expected results.
// Compile with the same MUL_ZERO_SKIP_EN setting as the RTL.
module tb_mul_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         eqz;
  logic [W-1:0] data_out;
  logic         lda, ldb, clrp, ldp, decb, busy, done;

  int tests = 0;
  int fails = 0;

  mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .eqz(eqz), .data_out(data_out), .lda(lda), .ldb(ldb), .clrp(clrp),
    .ldp(ldp), .decb(decb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural mul_datapath
  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_p = '0;
  assign eqz = (dp_b == '0);
  always_ff @(posedge clk) begin
    if (lda) dp_a <= data_out;
    if (ldb) dp_b <= data_out;
    else if (decb) dp_b <= dp_b - 1'b1;
    if (clrp) dp_p <= '0;
    else if (ldp) dp_p <= dp_p + dp_a;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
  } vec_t;

  typedef struct {
    logic [W-1:0] prod;
    int           lat;
    int           pulses;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit zero_skip(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Expected {data_out, lda, ldb, clrp, ldp, decb, busy, done} in cycle cyc after start.
  function automatic logic [W+6:0] exp_outs(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int cyc);
    int bb;
    bb = int'(b);
    if (zero_skip(a, b)) begin
      if (cyc == 1) return {16'd0, 7'b0110010};
      if (cyc == 2) return {16'd0, 7'b0000010};
      if (cyc == 3) return {16'd0, 7'b0000001};
      return '0;
    end
    if (cyc == 1) return {a, 7'b1000010};
    if (cyc == 2) return {b, 7'b0110010};
    if (cyc >= 3 && cyc <= 2 + bb) return {16'd0, 7'b0001110};
    if (cyc == 3 + bb) return {16'd0, 7'b0000010};
    if (cyc == 4 + bb) return {16'd0, 7'b0000001};
    return '0;
  endfunction

  // Runs one operation; optionally pulses a second start at cycle glitch_at.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] prod, input string tag,
                        input int glitch_at, input logic [W-1:0] ga, input logic [W-1:0] gb);
    exp_t e, got;
    int cyc, npulse, bad;
    bit fin;
    logic [W+6:0] act, expv;
    e.prod   = prod;
    e.lat    = zero_skip(a, b) ? 3 : int'(b) + 4;
    e.pulses = zero_skip(a, b) ? 0 : int'(b);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    sb.push_back(e);
    cyc = 0; npulse = 0; bad = 0; fin = 1'b0;
    while (!fin && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == glitch_at) begin
        start = 1'b1; a_in = ga; b_in = gb;
      end
      act  = {data_out, lda, ldb, clrp, ldp, decb, busy, done};
      expv = exp_outs(a, b, cyc);
      if (act != expv) begin
        if (bad == 0)
          $display("  %s cycle %0d outputs got %h, expected %h", tag, cyc, act, expv);
        bad++;
      end
      if (ldp) npulse++;
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    check({tag, " bad_output_cycles"}, bad, 0);
    check({tag, " scoreboard_nonempty"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, " done_cycle"}, cyc, got.lat);
      check({tag, " ldp_pulses"}, npulse, got.pulses);
      check({tag, " product"}, int'(dp_p), int'(got.prod));
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 16'd5,     b: 16'd3,    prod: 16'd15};
    vecs[1] = '{a: 16'd9,     b: 16'd0,    prod: 16'd0};
    vecs[2] = '{a: 16'd0,     b: 16'd1000, prod: 16'd0};
    vecs[3] = '{a: 16'd300,   b: 16'd300,  prod: 16'd24464};
    vecs[4] = '{a: 16'd65535, b: 16'd2,    prod: 16'd65534};
    vecs[5] = '{a: 16'd1,     b: 16'd1,    prod: 16'd1};

    #1;
    check("reset outputs", int'({data_out, lda, ldb, clrp, ldp, decb, busy, done}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle outputs", int'({data_out, lda, ldb, clrp, ldp, decb, busy, done}), 0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i), -1, '0, '0);

    // Second start mid-ADD must be ignored.
    run_op(16'd4, 16'd10, 16'd40, "busy_start", 5, 16'd7, 16'd2);
    run_op(16'd7, 16'd2, 16'd14, "after_busy", -1, '0, '0);

    // Asynchronous reset in the middle of ADD.
    @(negedge clk);
    start = 1'b1; a_in = 16'd5; b_in = 16'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_add busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({data_out, lda, ldb, clrp, ldp, decb, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset idle", int'({data_out, lda, ldb, clrp, ldp, decb, busy, done}), 0);
    run_op(16'd6, 16'd2, 16'd12, "after_reset", -1, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
